// File: rtl/dmem_resp_ctrl.sv
// dmem_resp_ctrl
//   Responder end of the ASIP data-memory interface. Serves processor
//   read/write requests from an internal banked word store. Writes are
//   posted through a one-entry buffer, and reads forward from that buffer.
//   A host port can load or dump memory while the core is deselected.
//
// Optional build macro: DMEM_PARITY_EN
//   Adds an even-parity bit per stored word, the par_err output and the
//   par_inj test hook.
//
// Ports
//   clk, reset              clock, synchronous active-high reset
//   t_cs                    1 = processor owns memory, 0 = host may be served
//   dmem_rw/en_b/cs/addr    processor request (rw 1 = read, en_b active low)
//   dmem_wdat, dmem_rdat    processor write data / read data (latency 1)
//   host_req/rw/addr/wdat   host request (level, held until host_ack)
//   host_ack, host_rdat     one-cycle completion pulse, host read data
//   busy                    write buffer holds an uncommitted entry
//   par_err, par_inj        parity error pulse / parity inject (macro only)
//
// Host FSM
//   state    | meaning
//   H_IDLE   | waiting for host_req with t_cs low and write buffer empty
//   H_ACCESS | host read latches data, or host write updates storage
//   H_ACK    | host_ack high for one cycle
module dmem_resp_ctrl #(
  parameter int DW  = 32,
  parameter int CSW = 2,
  parameter int AW  = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              t_cs,
  input  logic              dmem_rw,
  input  logic              dmem_en_b,
  input  logic [CSW-1:0]    dmem_cs,
  input  logic [AW-1:0]     dmem_addr,
  input  logic [DW-1:0]     dmem_wdat,
  output logic [DW-1:0]     dmem_rdat,
  input  logic              host_req,
  input  logic              host_rw,
  input  logic [CSW+AW-1:0] host_addr,
  input  logic [DW-1:0]     host_wdat,
  output logic              host_ack,
  output logic [DW-1:0]     host_rdat,
  output logic              busy
`ifdef DMEM_PARITY_EN
  ,
  output logic              par_err,
  input  logic              par_inj
`endif
);

  localparam int MAW   = CSW + AW;
  localparam int DEPTH = 2 ** MAW;

  typedef enum logic [1:0] {
    H_IDLE   = 2'd0,
    H_ACCESS = 2'd1,
    H_ACK    = 2'd2
  } h_state_t;

  h_state_t r_h_state;
  h_state_t w_h_next;

  logic [DW-1:0]  r_mem [DEPTH];

  logic           r_wb_vld;
  logic [MAW-1:0] r_wb_addr;
  logic [DW-1:0]  r_wb_dat;

  logic [DW-1:0]  r_rdat;
  logic [DW-1:0]  r_h_rdat;

  logic           w_p_req;
  logic           w_p_rd;
  logic           w_p_wr;
  logic [MAW-1:0] w_p_addr;
  logic           w_p_fwd;
  logic           w_h_fwd;
  logic [DW-1:0]  w_p_rd_dat;
  logic [DW-1:0]  w_h_rd_dat;
  logic           w_h_access;
  logic           w_h_ack;
  logic           w_h_wr;
  logic           w_h_rd;

  // Processor requests only count while the core owns memory.
  assign w_p_req  = ~dmem_en_b & t_cs;
  assign w_p_rd   = w_p_req & dmem_rw;
  assign w_p_wr   = w_p_req & ~dmem_rw;
  assign w_p_addr = {dmem_cs, dmem_addr};

  // The buffer entry commits on the same edge the read samples. So
  // forwarding also covers the read-and-commit-together case.
  assign w_p_fwd    = r_wb_vld && (r_wb_addr == w_p_addr);
  assign w_h_fwd    = r_wb_vld && (r_wb_addr == host_addr);
  assign w_p_rd_dat = w_p_fwd ? r_wb_dat : r_mem[w_p_addr];
  assign w_h_rd_dat = w_h_fwd ? r_wb_dat : r_mem[host_addr];

  assign w_h_wr = w_h_access & ~host_rw;
  assign w_h_rd = w_h_access & host_rw;

  // Host FSM: state register
  always_ff @(posedge clk) begin
    if (reset) r_h_state <= H_IDLE;
    else       r_h_state <= w_h_next;
  end

  // Host FSM: next state
  always_comb begin
    w_h_next = r_h_state;
    case (r_h_state)
      H_IDLE:   if (host_req && !t_cs && !r_wb_vld) w_h_next = H_ACCESS;
      H_ACCESS: w_h_next = H_ACK;
      H_ACK:    w_h_next = H_IDLE;
      default:  w_h_next = H_IDLE;
    endcase
  end

  // Host FSM: outputs
  always_comb begin
    w_h_access = 1'b0;
    w_h_ack    = 1'b0;
    case (r_h_state)
      H_ACCESS: w_h_access = 1'b1;
      H_ACK:    w_h_ack    = 1'b1;
      default:  ;
    endcase
  end

  // Posted write buffer. Reset drops any pending entry.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wb_vld  <= 1'b0;
      r_wb_addr <= '0;
      r_wb_dat  <= '0;
    end else begin
      r_wb_vld <= w_p_wr;
      if (w_p_wr) begin
        r_wb_addr <= w_p_addr;
        r_wb_dat  <= dmem_wdat;
      end
    end
  end

  // Storage is not cleared by reset. Reset does block commits, so an entry
  // caught by reset never reaches memory. The buffered commit is written
  // last, so a processor write to the same word lands after a host write.
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (w_h_wr)   r_mem[host_addr] <= host_wdat;
      if (r_wb_vld) r_mem[r_wb_addr] <= r_wb_dat;
    end
  end

  // Read data registers. Each one holds until its next read.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rdat   <= '0;
      r_h_rdat <= '0;
    end else begin
      if (w_p_rd) r_rdat   <= w_p_rd_dat;
      if (w_h_rd) r_h_rdat <= w_h_rd_dat;
    end
  end

  assign dmem_rdat = r_rdat;
  assign host_rdat = r_h_rdat;
  assign host_ack  = w_h_ack;
  assign busy      = r_wb_vld;

`ifdef DMEM_PARITY_EN
  logic r_par [DEPTH];
  logic r_wb_inj;
  logic r_par_err;
  logic w_p_perr;
  logic w_h_perr;

  // The inject request travels with the buffered write, so it flips the
  // parity bit of that write's commit.
  always_ff @(posedge clk) begin
    if (reset)       r_wb_inj <= 1'b0;
    else if (w_p_wr) r_wb_inj <= par_inj;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      if (w_h_wr)   r_par[host_addr] <= (^host_wdat) ^ par_inj;
      if (r_wb_vld) r_par[r_wb_addr] <= (^r_wb_dat) ^ r_wb_inj;
    end
  end

  // Forwarded data never went through storage, so it is never checked.
  assign w_p_perr = w_p_rd & ~w_p_fwd & ((^r_mem[w_p_addr]) ^ r_par[w_p_addr]);
  assign w_h_perr = w_h_rd & ~w_h_fwd & ((^r_mem[host_addr]) ^ r_par[host_addr]);

  always_ff @(posedge clk) begin
    if (reset) r_par_err <= 1'b0;
    else       r_par_err <= w_p_perr | w_h_perr;
  end

  assign par_err = r_par_err;
`endif

endmodule

// File: tb/tb_dmem_resp_ctrl.sv
module tb_dmem_resp_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        t_cs;
  logic        dmem_rw;
  logic        dmem_en_b;
  logic [1:0]  dmem_cs;
  logic [5:0]  dmem_addr;
  logic [31:0] dmem_wdat;
  logic [31:0] dmem_rdat;
  logic        host_req;
  logic        host_rw;
  logic [7:0]  host_addr;
  logic [31:0] host_wdat;
  logic        host_ack;
  logic [31:0] host_rdat;
  logic        busy;
`ifdef DMEM_PARITY_EN
  logic        par_err;
  logic        par_inj;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  dmem_resp_ctrl #(.DW(32), .CSW(2), .AW(6)) dut (
    .clk       (clk),
    .reset     (reset),
    .t_cs      (t_cs),
    .dmem_rw   (dmem_rw),
    .dmem_en_b (dmem_en_b),
    .dmem_cs   (dmem_cs),
    .dmem_addr (dmem_addr),
    .dmem_wdat (dmem_wdat),
    .dmem_rdat (dmem_rdat),
    .host_req  (host_req),
    .host_rw   (host_rw),
    .host_addr (host_addr),
    .host_wdat (host_wdat),
    .host_ack  (host_ack),
    .host_rdat (host_rdat),
    .busy      (busy)
`ifdef DMEM_PARITY_EN
    ,
    .par_err   (par_err),
    .par_inj   (par_inj)
`endif
  );

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cpu_wr(input logic [1:0] cs, input logic [5:0] a, input logic [31:0] d);
    dmem_en_b = 1'b0; dmem_rw = 1'b0; dmem_cs = cs; dmem_addr = a; dmem_wdat = d;
    tick();
    dmem_en_b = 1'b1;
  endtask

  task automatic cpu_rd(input logic [1:0] cs, input logic [5:0] a);
    dmem_en_b = 1'b0; dmem_rw = 1'b1; dmem_cs = cs; dmem_addr = a;
    tick();
    dmem_en_b = 1'b1;
  endtask

  // Issues one host request and returns the number of edges until host_ack.
  task automatic host_op(input logic rw, input logic [7:0] a, input logic [31:0] d,
                         output int cyc);
    host_req = 1'b1; host_rw = rw; host_addr = a; host_wdat = d;
    cyc = 0;
    while (!host_ack && cyc < 20) begin
      tick();
      cyc++;
    end
    host_req = 1'b0;
    tick();
  endtask

  initial begin
    int cyc;
    int busy_cnt;
    int ack_cnt;
    reset = 1'b1; t_cs = 1'b1; dmem_rw = 1'b1; dmem_en_b = 1'b1;
    dmem_cs = '0; dmem_addr = '0; dmem_wdat = '0;
    host_req = 1'b0; host_rw = 1'b0; host_addr = '0; host_wdat = '0;
`ifdef DMEM_PARITY_EN
    par_inj = 1'b0;
`endif
    tick(); tick();
    reset = 1'b0;
    chk_eq("rst_busy", {31'd0, busy}, 32'd0);
    chk_eq("rst_rdat", dmem_rdat, 32'd0);
    chk_eq("rst_hack", {31'd0, host_ack}, 32'd0);
    chk_eq("rst_hrdat", host_rdat, 32'd0);

    // Reset mid-write
    cpu_wr(2'd1, 6'd5, 32'h0BADF00D);
    tick();
    cpu_rd(2'd1, 6'd5);
    chk_eq("pre_rd", dmem_rdat, 32'h0BADF00D);
    cpu_wr(2'd1, 6'd5, 32'hDEADBEEF);
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    chk_eq("midrst_busy", {31'd0, busy}, 32'd0);
    chk_eq("midrst_rdat", dmem_rdat, 32'd0);
    cpu_rd(2'd1, 6'd5);
    chk_eq("midrst_rd", dmem_rdat, 32'h0BADF00D);

    // Write then read (forwarded), then from storage
    cpu_wr(2'd2, 6'd3, 32'h12345678);
    cpu_rd(2'd2, 6'd3);
    chk_eq("fwd_rd", dmem_rdat, 32'h12345678);
    repeat (5) tick();
    cpu_rd(2'd2, 6'd3);
    chk_eq("mem_rd", dmem_rdat, 32'h12345678);

    // Back-to-back writes
    busy_cnt = 0;
    for (int i = 0; i < 8; i++) begin
      cpu_wr(2'd0, 6'(i), 32'(i * 32'h11));
      if (busy) busy_cnt++;
    end
    tick();
    chk_eq("b2b_busy_cnt", 32'(busy_cnt), 32'd8);
    chk_eq("b2b_busy_end", {31'd0, busy}, 32'd0);
    for (int i = 0; i < 8; i++) begin
      cpu_rd(2'd0, 6'(i));
      chk_eq($sformatf("b2b_rd%0d", i), dmem_rdat, 32'(i * 32'h11));
    end

    // Requests while deselected are ignored
    t_cs = 1'b0;
    cpu_rd(2'd2, 6'd3);
    chk_eq("ign_rd", dmem_rdat, 32'h00000077);
    cpu_wr(2'd2, 6'd3, 32'hFFFFFFFF);
    chk_eq("ign_wr_busy", {31'd0, busy}, 32'd0);

    // Host port
    host_op(1'b0, 8'hFF, 32'hCAFEF00D, cyc);
    chk_eq("host_wr_lat", 32'(cyc), 32'd2);
    host_op(1'b1, 8'hFF, 32'd0, cyc);
    chk_eq("host_rd_lat", 32'(cyc), 32'd2);
    chk_eq("host_rdat", host_rdat, 32'hCAFEF00D);
    host_op(1'b1, 8'h83, 32'd0, cyc);
    chk_eq("host_rd_b2", host_rdat, 32'h12345678);
    t_cs = 1'b1;
    cpu_rd(2'd3, 6'd63);
    chk_eq("cpu_rd_hostw", dmem_rdat, 32'hCAFEF00D);

    // Arbitration
    host_req = 1'b1; host_rw = 1'b1; host_addr = 8'h45;
    ack_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (host_ack) ack_cnt++;
    end
    chk_eq("arb_no_ack", 32'(ack_cnt), 32'd0);
    t_cs = 1'b0;
    cyc = 0;
    while (!host_ack && cyc < 20) begin
      tick();
      cyc++;
    end
    chk_eq("arb_ack_lat", 32'(cyc), 32'd2);
    chk_eq("arb_rdat", host_rdat, 32'h0BADF00D);
    host_req = 1'b0;
    tick();
    t_cs = 1'b1;

`ifdef DMEM_PARITY_EN
    par_inj = 1'b1;
    cpu_wr(2'd1, 6'd9, 32'h00000001);
    par_inj = 1'b0;
    tick();
    cpu_rd(2'd1, 6'd9);
    chk_eq("par_err_hit", {31'd0, par_err}, 32'd1);
    tick();
    chk_eq("par_err_pulse", {31'd0, par_err}, 32'd0);
    cpu_wr(2'd1, 6'd10, 32'h00000003);
    tick();
    cpu_rd(2'd1, 6'd10);
    chk_eq("par_clean", {31'd0, par_err}, 32'd0);
    chk_eq("par_clean_dat", dmem_rdat, 32'h00000003);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
